fifo_ctrl: RTL

Pointer/flag controller that drives the FIFO storage array: the initiator side of the memory's wr_ptr/rd_ptr/FIFO_data_in interface. It accepts push/pop requests, issues write and read strobes with addresses to the memory, and tracks occupancy and full/empty/almost flags. It also delivers a data-valid strobe aligned to the memory's registered FIFO_data_out.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_if.sv | 34 +++
 rtl/fifo_ptr.sv | 21 ++
 rtl/fifo_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and FSM state encoding for the FIFO pointer/flag controller.
package fifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_if.sv
// Request/status bundle between a FIFO user (master) and fifo_ctrl (slave).
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  data_valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;

  modport master (
    output push, pop,
    input  wr_en, rd_en, wr_ptr, rd_ptr, data_valid, count,
           fifo_full, fifo_empty, almost_full, almost_empty, fifo_error
  );

  modport slave (
    input  push, pop,
    output wr_en, rd_en, wr_ptr, rd_ptr, data_valid, count,
           fifo_full, fifo_empty, almost_full, almost_empty, fifo_error
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping ADDR_WIDTH-bit pointer with enable and synchronous reset.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  output logic [ADDR_WIDTH-1:0] o_ptr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_ptr <= '0;
    end else if (i_en) begin
      o_ptr <= o_ptr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller: accepts push/pop, drives memory strobes and tracks occupancy.
// Define FIFO_ERROR_EN to build the sticky overflow/underflow register behind fifo_error.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned AF_THRESH  = 2**ADDR_WIDTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input logic   clk,
  input logic   reset,
  fifo_if.slave bus
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [CW-1:0]         r_count;
  logic                  r_data_valid;
  fifo_state_e           r_state;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_full;
  logic                  w_empty;
  logic [ADDR_WIDTH-1:0] w_wr_ptr;
  logic [ADDR_WIDTH-1:0] w_rd_ptr;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Acceptance uses this cycle's flags, so simultaneous push/pop never reads through.
  assign w_wr_en = bus.push & ~w_full  & ~reset;
  assign w_rd_en = bus.pop  & ~w_empty & ~reset;

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_wr_en),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_rd_en),
    .o_ptr (w_rd_ptr)
  );

  // Occupancy, read-data alignment and state tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= '0;
      r_data_valid <= 1'b0;
      r_state      <= ST_EMPTY;
    end else begin
      r_data_valid <= w_rd_en;
      if (w_wr_en && !w_rd_en) begin
        r_count <= r_count + CW'(1);
      end else if (w_rd_en && !w_wr_en) begin
        r_count <= r_count - CW'(1);
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_wr_en) r_state <= (DEPTH == 1) ? ST_FULL : ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_wr_en && !w_rd_en && r_count == CW'(DEPTH - 1)) begin
            r_state <= ST_FULL;
          end else if (w_rd_en && !w_wr_en && r_count == CW'(1)) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_rd_en) r_state <= ST_ACTIVE;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

`ifdef FIFO_ERROR_EN
  logic r_error;

  // Sticky until reset; set by any request rejected on a flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if ((bus.push && w_full) || (bus.pop && w_empty)) begin
      r_error <= 1'b1;
    end
  end

  assign bus.fifo_error = r_error;
`else
  assign bus.fifo_error = 1'b0;
`endif

  assign bus.wr_en        = w_wr_en;
  assign bus.rd_en        = w_rd_en;
  assign bus.wr_ptr       = w_wr_ptr;
  assign bus.rd_ptr       = w_rd_ptr;
  assign bus.data_valid   = r_data_valid;
  assign bus.count        = r_count;
  assign bus.fifo_full    = w_full;
  assign bus.fifo_empty   = w_empty;
  assign bus.almost_full  = (r_count >= CW'(AF_THRESH));
  assign bus.almost_empty = (r_count <= CW'(AE_THRESH));

endmodule
